hazard_controller: RTL and testbench
====================================

// Module: hazard_controller
// PURPOSE
//  Pipeline sequencer for the 5-stage CPU; sits beside forwarding_unit and owns every stall/flush decision.
//  Detects load-use hazards, flushes IF/ID and ID/EX on a taken branch, and holds the front end while a multi-cycle mul/div occupies EX.
//  Keeps saturating stall/flush performance counters.
// PARAMETERS
//  MD_CYCLES   4    total EX-stage occupancy of a mul/div op, in cycles; legal range 2..16
//  CNT_WIDTH   32   width of each performance counter
// PORTS
//  clk              in   1   single clock; all state updates on rising edge
//  rst              in   1   synchronous, active-high reset
//  ID_EX_memRead    in   1   instruction in EX is a load
//  ID_EX_mulDiv     in   1   instruction in EX is mul/div
//  ID_EX_rt         in   5   load destination register (EX)
//  IF_ID_rs         in   5   rs of the instruction in ID
//  IF_ID_rt         in   5   rt of the instruction in ID
//  branch_taken     in   1   taken branch/jump resolved in EX this cycle
//  md_done          in   1   mul/div unit early-finish strobe
//  PCWrite          out  1   1 = PC may update
//  IF_ID_write      out  1   1 = IF/ID may load
//  ID_EX_write      out  1   1 = ID/EX may load; 0 holds EX
//  ID_EX_bubble     out  1   zero control bits entering ID/EX
//  EX_MEM_bubble    out  1   zero control bits entering EX/MEM
//  IF_ID_flush      out  1   clear IF/ID
//  md_start         out  1   one-cycle start pulse to mul/div unit
//  stall_count      out  CNT_WIDTH  cycles with PCWrite=0
//  flush_count      out  CNT_WIDTH  taken-branch flush events
// BEHAVIOUR
//  Default (no event): all *_write = 1; bubbles, flush and md_start = 0. Outputs are combinational from state + inputs.
//  While rst=1: state<=RUN, cnt<=0, both counters<=0; outputs forced to defaults. Reset mid-mul/div abandons the op; no md_start follows.
//  FSM states: RUN, MD_WAIT. Down-counter cnt is $clog2(MD_CYCLES) bits wide.
//  RUN, priority order (highest first):
//   1 branch_taken: IF_ID_flush=1, ID_EX_bubble=1, PCWrite=1; flush_count++; stay in RUN.
//   2 ID_EX_mulDiv: md_start=1, PCWrite=0, IF_ID_write=0, ID_EX_write=0, EX_MEM_bubble=1; cnt<=MD_CYCLES-2; go to MD_WAIT.
//   3 load-use, i.e. ID_EX_memRead & ID_EX_rt!=0 & (ID_EX_rt==IF_ID_rs | ID_EX_rt==IF_ID_rt):
//     PCWrite=0, IF_ID_write=0, ID_EX_bubble=1; stay in RUN. Stalls exactly 1 cycle, because the bubble clears ID_EX_memRead.
//  MD_WAIT:
//   - If cnt==0 or md_done: release (defaults, no stall); go to RUN.
//   - Else: same stall outputs as the entry cycle, md_start=0; cnt--.
//   - branch_taken, load-use and ID_EX_mulDiv are ignored; EX holds the mul/div op.
//  Mul/div timing: the op sits in EX for exactly MD_CYCLES cycles (fewer if md_done).
//   The front end is stalled for the first MD_CYCLES-1 of them and advances on the last.
//  Back-to-back mul/div: the next op reaches EX after release and is detected in RUN. md_start re-pulses; there is no idle cycle between ops.
//  stall_count increments every cycle PCWrite=0; flush_count increments per branch flush.
//  Both counters saturate at all-ones and never wrap.
//  Register 0 never causes a load-use stall.
// STRUCTURE
//  Shared header hazard_defs.vh holds:
//   - state encodings HZ_RUN=1'b0, HZ_MD_WAIT=1'b1
//   - MD_CYCLES default
//  Sub-module load_use_detector (combinational): inputs ID_EX_memRead, ID_EX_rt, IF_ID_rs, IF_ID_rt; output hazard.
//  FSM, cnt and perf counters live in hazard_controller.
// TESTING
//  1 rst=1 for 2 cycles, then idle -> PCWrite=IF_ID_write=ID_EX_write=1, all bubble/flush/md_start=0, both counters=0.
//  2 memRead=1, ID_EX_rt=5, IF_ID_rs=5 for 1 cycle, then memRead=0 -> exactly 1 cycle PCWrite=0, ID_EX_bubble=1; stall_count=1.
//    Repeat with ID_EX_rt=0 -> no stall.
//  3 branch_taken=1 together with a load-use match on rt=7 -> IF_ID_flush=1, ID_EX_bubble=1, PCWrite=1; flush_count=1, stall_count unchanged.
//  4 ID_EX_mulDiv=1, MD_CYCLES=4, md_done=0 -> md_start for 1 cycle, 3 stalled cycles, release on 4th; stall_count=3.
//    branch_taken asserted during the wait is ignored.
//  5 mul/div with md_done=1 in the 1st MD_WAIT cycle -> stall lasts 1 cycle total.
//    Two back-to-back mul/div ops -> two md_start pulses, 6 stall cycles.
//  6 rst=1 in the 2nd MD_WAIT cycle -> next cycle in RUN with default outputs, counters=0; no release glitch or extra md_start.

Source files
------------

// File: rtl/hazard_controller_pkg.sv
// Shared types and defaults for the pipeline hazard sequencer.
// State encodings and parameter defaults used across the block.
package hazard_controller_pkg;

  typedef enum logic {
    HZ_RUN     = 1'b0,
    HZ_MD_WAIT = 1'b1
  } hz_state_t;

  localparam int MD_CYCLES_DEF = 4;
  localparam int CNT_WIDTH_DEF = 32;

endpackage

// File: rtl/hazard_controller_lud.sv
// Combinational load-use hazard detector.
// Register 0 is hardwired, so it never creates a dependency.
module load_use_detector (
  input  logic       ID_EX_memRead,
  input  logic [4:0] ID_EX_rt,
  input  logic [4:0] IF_ID_rs,
  input  logic [4:0] IF_ID_rt,
  output logic       hazard
);

  logic rs_hit;
  logic rt_hit;

  assign rs_hit = (ID_EX_rt == IF_ID_rs);
  assign rt_hit = (ID_EX_rt == IF_ID_rt);

  assign hazard = ID_EX_memRead
                & (ID_EX_rt != 5'd0)
                & (rs_hit | rt_hit);

endmodule

// File: rtl/hazard_controller.sv
// Pipeline stall/flush sequencer: load-use, taken branch, mul/div hold.
// Also keeps saturating stall and flush performance counters.
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int MD_CYCLES = MD_CYCLES_DEF,
  parameter int CNT_WIDTH = CNT_WIDTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ID_EX_memRead,
  input  logic                 ID_EX_mulDiv,
  input  logic [4:0]           ID_EX_rt,
  input  logic [4:0]           IF_ID_rs,
  input  logic [4:0]           IF_ID_rt,
  input  logic                 branch_taken,
  input  logic                 md_done,
  output logic                 PCWrite,
  output logic                 IF_ID_write,
  output logic                 ID_EX_write,
  output logic                 ID_EX_bubble,
  output logic                 EX_MEM_bubble,
  output logic                 IF_ID_flush,
  output logic                 md_start,
  output logic [CNT_WIDTH-1:0] stall_count,
  output logic [CNT_WIDTH-1:0] flush_count
);

  localparam int CW = $clog2(MD_CYCLES);

  hz_state_t     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          hazard;

  load_use_detector u_lud (
    .ID_EX_memRead (ID_EX_memRead),
    .ID_EX_rt      (ID_EX_rt),
    .IF_ID_rs      (IF_ID_rs),
    .IF_ID_rt      (IF_ID_rt),
    .hazard        (hazard)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= HZ_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    PCWrite       = 1'b1;
    IF_ID_write   = 1'b1;
    ID_EX_write   = 1'b1;
    ID_EX_bubble  = 1'b0;
    EX_MEM_bubble = 1'b0;
    IF_ID_flush   = 1'b0;
    md_start      = 1'b0;
    unique case (state_q)
      HZ_RUN: begin
        if (branch_taken) begin
          IF_ID_flush  = 1'b1;
          ID_EX_bubble = 1'b1;
        end else if (ID_EX_mulDiv) begin
          md_start      = 1'b1;
          PCWrite       = 1'b0;
          IF_ID_write   = 1'b0;
          ID_EX_write   = 1'b0;
          EX_MEM_bubble = 1'b1;
          cnt_d         = CW'(MD_CYCLES - 2);
          state_d       = HZ_MD_WAIT;
        end else if (hazard) begin
          PCWrite      = 1'b0;
          IF_ID_write  = 1'b0;
          ID_EX_bubble = 1'b1;
        end
      end
      HZ_MD_WAIT: begin
        if (cnt_q == '0 || md_done) begin
          state_d = HZ_RUN;
        end else begin
          PCWrite       = 1'b0;
          IF_ID_write   = 1'b0;
          ID_EX_write   = 1'b0;
          EX_MEM_bubble = 1'b1;
          cnt_d         = cnt_q - CW'(1);
        end
      end
      default: state_d = HZ_RUN;
    endcase
    // Reset masks everything so an abandoned op cannot leak a pulse.
    if (rst) begin
      PCWrite       = 1'b1;
      IF_ID_write   = 1'b1;
      ID_EX_write   = 1'b1;
      ID_EX_bubble  = 1'b0;
      EX_MEM_bubble = 1'b0;
      IF_ID_flush   = 1'b0;
      md_start      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (!PCWrite && stall_count != '1)
        stall_count <= stall_count + CNT_WIDTH'(1);
      if (IF_ID_flush && flush_count != '1)
        flush_count <= flush_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller with hand-computed vectors.
// Output vector: {PCWrite,IF_ID_write,ID_EX_write,ID_EX_bubble,EX_MEM_bubble,IF_ID_flush,md_start}.
module tb_hazard_controller;

  logic        clk = 1'b0;
  logic        rst;
  logic        ID_EX_memRead;
  logic        ID_EX_mulDiv;
  logic [4:0]  ID_EX_rt;
  logic [4:0]  IF_ID_rs;
  logic [4:0]  IF_ID_rt;
  logic        branch_taken;
  logic        md_done;
  logic        PCWrite;
  logic        IF_ID_write;
  logic        ID_EX_write;
  logic        ID_EX_bubble;
  logic        EX_MEM_bubble;
  logic        IF_ID_flush;
  logic        md_start;
  logic [31:0] stall_count;
  logic [31:0] flush_count;
  logic [6:0]  outv;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [6:0] DEF = 7'b1110000;
  localparam logic [6:0] LU  = 7'b0011000;
  localparam logic [6:0] BR  = 7'b1111010;
  localparam logic [6:0] MDS = 7'b0000101;
  localparam logic [6:0] MDW = 7'b0000100;

  always #5 clk = ~clk;

  hazard_controller #(.MD_CYCLES(4), .CNT_WIDTH(32)) dut (
    .clk           (clk),
    .rst           (rst),
    .ID_EX_memRead (ID_EX_memRead),
    .ID_EX_mulDiv  (ID_EX_mulDiv),
    .ID_EX_rt      (ID_EX_rt),
    .IF_ID_rs      (IF_ID_rs),
    .IF_ID_rt      (IF_ID_rt),
    .branch_taken  (branch_taken),
    .md_done       (md_done),
    .PCWrite       (PCWrite),
    .IF_ID_write   (IF_ID_write),
    .ID_EX_write   (ID_EX_write),
    .ID_EX_bubble  (ID_EX_bubble),
    .EX_MEM_bubble (EX_MEM_bubble),
    .IF_ID_flush   (IF_ID_flush),
    .md_start      (md_start),
    .stall_count   (stall_count),
    .flush_count   (flush_count)
  );

  assign outv = {PCWrite, IF_ID_write, ID_EX_write, ID_EX_bubble,
                 EX_MEM_bubble, IF_ID_flush, md_start};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp)
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Check outputs mid-cycle, then advance past the next rising edge.
  task automatic cyc(input string tag, input logic [6:0] exp);
    @(negedge clk);
    chk(tag, 32'(outv), 32'(exp));
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ID_EX_memRead = 1'b0;
    ID_EX_mulDiv  = 1'b0;
    ID_EX_rt      = 5'd0;
    IF_ID_rs      = 5'd0;
    IF_ID_rt      = 5'd0;
    branch_taken  = 1'b0;
    md_done       = 1'b0;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    ID_EX_mulDiv = 1'b1;
    cyc("rst_mask0", DEF);
    cyc("rst_mask1", DEF);
    rst = 1'b0;
    idle();
    cyc("idle", DEF);
    chk("rst_stall", stall_count, 32'd0);
    chk("rst_flush", flush_count, 32'd0);

    ID_EX_memRead = 1'b1; ID_EX_rt = 5'd5; IF_ID_rs = 5'd5;
    cyc("lu_rs", LU);
    ID_EX_memRead = 1'b0;
    cyc("lu_after", DEF);
    chk("lu_stall1", stall_count, 32'd1);

    ID_EX_memRead = 1'b1; ID_EX_rt = 5'd0; IF_ID_rs = 5'd0;
    cyc("lu_r0", DEF);
    ID_EX_rt = 5'd9; IF_ID_rs = 5'd3; IF_ID_rt = 5'd9;
    cyc("lu_rt", LU);
    ID_EX_rt = 5'd5; IF_ID_rs = 5'd6; IF_ID_rt = 5'd7;
    cyc("lu_miss", DEF);
    chk("lu_stall2", stall_count, 32'd2);

    ID_EX_rt = 5'd7; IF_ID_rs = 5'd7; branch_taken = 1'b1;
    cyc("br_prio", BR);
    idle();
    cyc("br_after", DEF);
    chk("br_flush", flush_count, 32'd1);
    chk("br_stall", stall_count, 32'd2);

    ID_EX_mulDiv = 1'b1;
    cyc("md_start", MDS);
    branch_taken = 1'b1;
    cyc("md_w1", MDW);
    cyc("md_w2", MDW);
    idle();
    cyc("md_rel", DEF);
    cyc("md_idle", DEF);
    chk("md_stall", stall_count, 32'd5);
    chk("md_flush", flush_count, 32'd1);

    ID_EX_mulDiv = 1'b1;
    cyc("mdd_start", MDS);
    ID_EX_mulDiv = 1'b0; md_done = 1'b1;
    cyc("mdd_rel", DEF);
    md_done = 1'b0;
    cyc("mdd_idle", DEF);
    chk("mdd_stall", stall_count, 32'd6);

    ID_EX_mulDiv = 1'b1;
    cyc("b2b_s1", MDS);
    cyc("b2b_w1a", MDW);
    cyc("b2b_w1b", MDW);
    cyc("b2b_r1", DEF);
    cyc("b2b_s2", MDS);
    cyc("b2b_w2a", MDW);
    cyc("b2b_w2b", MDW);
    ID_EX_mulDiv = 1'b0;
    cyc("b2b_r2", DEF);
    chk("b2b_stall", stall_count, 32'd12);

    ID_EX_mulDiv = 1'b1;
    cyc("rmd_start", MDS);
    cyc("rmd_w1", MDW);
    rst = 1'b1;
    cyc("rmd_rst", DEF);
    rst = 1'b0;
    ID_EX_mulDiv = 1'b0;
    chk("rmd_stall", stall_count, 32'd0);
    chk("rmd_flush", flush_count, 32'd0);
    cyc("rmd_run", DEF);
    cyc("rmd_run2", DEF);
    chk("rmd_stall2", stall_count, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
